// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receive-only PS/2 keyboard front end.
// Synchronizes the raw PS/2 lines, deserializes device-to-host frames, resolves the
// E0 (extended) and F0 (break) prefixes and keeps held-key levels for the game controls.
// Optional feature: define PS2_PARITY_CHECK_EN to require odd parity in the STOP state.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_ext,
    output logic       scan_break,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    localparam logic [7:0] CodeExt = 8'hE0;
    localparam logic [7:0] CodeBrk = 8'hF0;

    // Key level vector bit positions.
    localparam int unsigned KUp    = 4;
    localparam int unsigned KDown  = 3;
    localparam int unsigned KLeft  = 2;
    localparam int unsigned KRight = 1;
    localparam int unsigned KFire  = 0;

    // Synchronizer flops; idle-high so reset release never looks like a falling edge.
    logic c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic d1_q, d1_d, d2_q, d2_d;
    logic fall;

    // Receiver state.
    logic [1:0]      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_q, par_d;
`endif

    // Registered outputs.
    logic [7:0] scan_code_q, scan_code_d;
    logic       scan_ext_q, scan_ext_d;
    logic       scan_break_q, scan_break_d;
    logic       scan_valid_q, scan_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [4:0] keys_q, keys_d;

    logic       tmo_hit;
    logic       byte_ok;
    logic       parity_ok;
    logic [4:0] key_hit;

    // Synchronizer next state: two flops per line plus a delayed clock copy for edge detect.
    always_comb begin
        c1_d = ps2_clk;
        c2_d = c1_q;
        c3_d = c2_q;
        d1_d = ps2_dat;
        d2_d = d1_q;
    end

    assign fall    = c3_q & ~c2_q;
    assign tmo_hit = (state_q != StIdle) && (tmo_q == TmoLast);

    // Stop-bit acceptance condition; without the macro the parity bit is ignored.
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        parity_ok = ^{shift_q, par_q};
`else
        parity_ok = 1'b1;
`endif
    end

    // Map the completed byte (with the pending extended flag) onto a key level bit.
    always_comb begin
        key_hit = 5'b0;
        if (ext_q) begin
            case (shift_q)
                8'h75:   key_hit[KUp]    = 1'b1;
                8'h72:   key_hit[KDown]  = 1'b1;
                8'h6B:   key_hit[KLeft]  = 1'b1;
                8'h74:   key_hit[KRight] = 1'b1;
                default: key_hit = 5'b0;
            endcase
        end else begin
            case (shift_q)
                8'h1D:   key_hit[KUp]    = 1'b1;
                8'h1B:   key_hit[KDown]  = 1'b1;
                8'h1C:   key_hit[KLeft]  = 1'b1;
                8'h23:   key_hit[KRight] = 1'b1;
                8'h29:   key_hit[KFire]  = 1'b1;
                default: key_hit = 5'b0;
            endcase
        end
    end

    // Frame FSM, timeout watchdog, prefix tracking and output/key-level next state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
`ifdef PS2_PARITY_CHECK_EN
        par_d        = par_q;
`endif
        scan_code_d  = scan_code_q;
        scan_ext_d   = scan_ext_q;
        scan_break_d = scan_break_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        keys_d       = keys_q;
        byte_ok      = 1'b0;

        // Watchdog only runs inside a frame and restarts on every clock edge.
        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        if (tmo_hit) begin
            // Timeout beats a coincident edge: the edge is dropped.
            state_d     = StIdle;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            tmo_d       = '0;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!d2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d[bit_cnt_q] = d2_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                StParity: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = d2_q;
`endif
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (d2_q && parity_ok) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (byte_ok) begin
            if (shift_q == CodeExt) begin
                ext_d = 1'b1;
            end else if (shift_q == CodeBrk) begin
                brk_d = 1'b1;
            end else begin
                scan_code_d  = shift_q;
                scan_ext_d   = ext_q;
                scan_break_d = brk_q;
                scan_valid_d = 1'b1;
                ext_d        = 1'b0;
                brk_d        = 1'b0;
                if (brk_q) begin
                    keys_d = keys_q & ~key_hit;
                end else begin
                    keys_d = keys_q | key_hit;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            c1_q         <= 1'b1;
            c2_q         <= 1'b1;
            c3_q         <= 1'b1;
            d1_q         <= 1'b1;
            d2_q         <= 1'b1;
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            tmo_q        <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= 1'b0;
`endif
            scan_code_q  <= 8'h00;
            scan_ext_q   <= 1'b0;
            scan_break_q <= 1'b0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            keys_q       <= 5'b0;
        end else begin
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            c3_q         <= c3_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= par_d;
`endif
            scan_code_q  <= scan_code_d;
            scan_ext_q   <= scan_ext_d;
            scan_break_q <= scan_break_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
            keys_q       <= keys_d;
        end
    end

    assign scan_code  = scan_code_q;
    assign scan_ext   = scan_ext_q;
    assign scan_break = scan_break_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;
    assign key_up     = keys_q[KUp];
    assign key_down   = keys_q[KDown];
    assign key_left   = keys_q[KLeft];
    assign key_right  = keys_q[KRight];
    assign key_fire   = keys_q[KFire];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by random frames,
// checked against a byte-level reference model of the prefix/key-level rules.
module tb_ps2_key_decoder;

    localparam int unsigned TMO  = 50000;
    localparam int unsigned HALF = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic [7:0] scan_code;
    logic       scan_ext, scan_break, scan_valid, frame_err;
    logic       key_up, key_down, key_left, key_right, key_fire;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .scan_code (scan_code),
        .scan_ext  (scan_ext),
        .scan_break(scan_break),
        .scan_valid(scan_valid),
        .frame_err (frame_err),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_fire  (key_fire)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts high cycles and captures the outputs seen with scan_valid.
    int         sv_cnt = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] cap_code;
    logic       cap_ext, cap_brk;
    logic [4:0] cap_keys;

    always @(posedge CLOCK_50) begin
        #1;
        if (scan_valid) begin
            sv_cnt++;
            cap_code = scan_code;
            cap_ext  = scan_ext;
            cap_brk  = scan_break;
            cap_keys = {key_up, key_down, key_left, key_right, key_fire};
        end
        if (frame_err) fe_cnt++;
        if (scan_valid && frame_err) both_cnt++;
    end

    // Reference model state: keys as {up, down, left, right, fire}.
    logic       m_ext = 1'b0, m_brk = 1'b0;
    logic [4:0] m_keys = 5'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_sext = 1'b0, m_sbrk = 1'b0;

    function automatic logic [4:0] key_of(input logic ext, input logic [7:0] code);
        if (ext) begin
            if (code == 8'h75) return 5'b10000;
            if (code == 8'h72) return 5'b01000;
            if (code == 8'h6B) return 5'b00100;
            if (code == 8'h74) return 5'b00010;
            return 5'b00000;
        end
        if (code == 8'h1D) return 5'b10000;
        if (code == 8'h1B) return 5'b01000;
        if (code == 8'h1C) return 5'b00100;
        if (code == 8'h23) return 5'b00010;
        if (code == 8'h29) return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic logic [16:0] live_outs();
        return {scan_code, scan_ext, scan_break, scan_valid, frame_err,
                key_up, key_down, key_left, key_right, key_fire};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge CLOCK_50);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        ps2_clk = 1'b1;
    endtask

    // Send one frame, update the model, and compare pulses and outputs.
    task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
        int   sv0 = sv_cnt;
        int   fe0 = fe_cnt;
        logic par = (~^data) ^ bad_par;
        logic accepted;
        int   exp_sv = 0;
        int   exp_fe = 0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i]);
        ps2_bit(par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        accepted = !bad_stop && !(bad_par && PAR_EN);
        if (!accepted) begin
            exp_fe = 1;
        end else if (data == 8'hE0) begin
            m_ext = 1'b1;
        end else if (data == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_sv = 1;
            m_code = data;
            m_sext = m_ext;
            m_sbrk = m_brk;
            if (m_brk) m_keys = m_keys & ~key_of(m_ext, data);
            else       m_keys = m_keys | key_of(m_ext, data);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end

        check_eq($sformatf("sv_pulses[%0h]", data), sv_cnt - sv0, exp_sv);
        check_eq($sformatf("fe_pulses[%0h]", data), fe_cnt - fe0, exp_fe);
        if (exp_sv == 1) begin
            check_eq($sformatf("cap_code[%0h]", data), cap_code, data);
            check_eq($sformatf("cap_ext[%0h]", data), cap_ext, m_sext);
            check_eq($sformatf("cap_brk[%0h]", data), cap_brk, m_sbrk);
            check_eq($sformatf("cap_keys[%0h]", data), cap_keys, m_keys);
        end
        check_eq($sformatf("hold[%0h]", data), {scan_code, scan_ext, scan_break},
                 {m_code, m_sext, m_sbrk});
        check_eq($sformatf("keys[%0h]", data),
                 {key_up, key_down, key_left, key_right, key_fire}, m_keys);
    endtask

    logic [7:0] pool [13] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                              8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFA};

    initial begin
        int sv0, fe0, n, at, sel, err;
        logic [7:0] b;

        repeat (5) @(negedge CLOCK_50);
        check_eq("reset_outs", live_outs(), 17'h0);
        reset = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        check_eq("post_reset_outs", live_outs(), 17'h0);

        // W make then break.
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        // Extended left arrow make then break.
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        // Bad stop bit, then bad parity.
        send_frame(8'h29, 1'b0, 1'b1);
        send_frame(8'h29, 1'b1, 1'b0);

        // Timeout: pending E0, then start + 4 data bits and a stalled clock.
        send_frame(8'hE0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_dat = 1'b0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        repeat (HALF) @(negedge CLOCK_50);
        ps2_clk = 1'b0;
        n = 0;
        at = 0;
        while (at == 0 && n < int'(TMO) + 50) begin
            @(posedge CLOCK_50);
            #1;
            n++;
            if (n == int'(HALF)) ps2_clk = 1'b1;
            if (frame_err) at = n;
        end
        ps2_dat = 1'b1;
        check_eq("tmo_edge", at, TMO + 3);
        repeat (4) @(negedge CLOCK_50);
        check_eq("tmo_fe_pulses", fe_cnt - fe0, 1);
        check_eq("tmo_sv_pulses", sv_cnt - sv0, 0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_frame(8'h74, 1'b0, 1'b0);

        // Reset mid-frame with a key held.
        send_frame(8'h1D, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        reset = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        check_eq("rst_mid_outs", live_outs(), 17'h0);
        reset = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        check_eq("rst_mid_after", live_outs(), 17'h0);
        check_eq("rst_mid_pulses", (sv_cnt - sv0) + (fe_cnt - fe0), 0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_keys = 5'b0;
        m_code = 8'h00;
        m_sext = 1'b0;
        m_sbrk = 1'b0;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);

        // Random frames.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 13);
            if (sel == 13) b = 8'($urandom_range(0, 255));
            else b = pool[sel];
            err = $urandom_range(0, 19);
            send_frame(b, err == 1, err == 0);
        end

        check_eq("sv_fe_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
